ann_coef_fetcher: RTL and testbench

//  Sequences the shared coefficient/image SRAM read port for the ANN datapath.
//  On a request from the ANN controller it streams one block into the layer buffer:
//  - the input image, or
//  - the weight set of the selected layer.
//  It then pulses image_weights_loaded for one cycle.

---
 rtl/ann_coef_fetcher.sv | 141 ++++++++++++++
 tb/tb_ann_coef_fetcher.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ann_coef_fetcher.sv
// Streams one coefficient or image block from the shared SRAM read port into the
// layer buffer, one word per READ/WRITE pair, then pulses image_weights_loaded.
module ann_coef_fetcher #(
  parameter int IMAGE_SIZE   = 64,
  parameter int FIRST_LAYER  = 16,
  parameter int SECOND_LAYER = 8,
  parameter int THIRD_LAYER  = 10,
  parameter int BASE_ADDR    = 0,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int IDX_W        = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request_coef,
  input  logic [1:0]        coef_select,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_index,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              image_weights_loaded,
  output logic              req_err
);

  localparam int LEN_W = IDX_W + 1;
  localparam int SUM_W = (ADDR_W > IDX_W) ? ADDR_W : IDX_W;

  localparam int L0_WORDS = IMAGE_SIZE * FIRST_LAYER;
  localparam int L1_WORDS = FIRST_LAYER * SECOND_LAYER;
  localparam int L2_WORDS = SECOND_LAYER * THIRD_LAYER;

  // Blocks are laid out image, L0, L1, L2 contiguously from BASE_ADDR
  localparam logic [ADDR_W-1:0] IMG_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] L0_BASE  = ADDR_W'(BASE_ADDR + IMAGE_SIZE);
  localparam logic [ADDR_W-1:0] L1_BASE  = ADDR_W'(BASE_ADDR + IMAGE_SIZE + L0_WORDS);
  localparam logic [ADDR_W-1:0] L2_BASE  = ADDR_W'(BASE_ADDR + IMAGE_SIZE + L0_WORDS + L1_WORDS);

  localparam logic [LEN_W-1:0] IMG_LEN = LEN_W'(IMAGE_SIZE);
  localparam logic [LEN_W-1:0] L0_LEN  = LEN_W'(L0_WORDS);
  localparam logic [LEN_W-1:0] L1_LEN  = LEN_W'(L1_WORDS);
  localparam logic [LEN_W-1:0] L2_LEN  = LEN_W'(L2_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [IDX_W-1:0]  idx;

  logic [ADDR_W-1:0] sel_base;
  logic [LEN_W-1:0]  sel_len;
  logic [SUM_W-1:0]  addr_sum;
  logic [ADDR_W-1:0] next_addr;
  logic              idx_last;

  always_comb begin
    sel_base = IMG_BASE;
    sel_len  = IMG_LEN;
    case (coef_select)
      2'b00: begin sel_base = L0_BASE;  sel_len = L0_LEN;  end
      2'b01: begin sel_base = L1_BASE;  sel_len = L1_LEN;  end
      2'b10: begin sel_base = L2_BASE;  sel_len = L2_LEN;  end
      default: begin sel_base = IMG_BASE; sel_len = IMG_LEN; end
    endcase
  end

  // Address of the word following idx; wraps silently at ADDR_W
  assign addr_sum  = SUM_W'(base) + SUM_W'(idx) + SUM_W'(1);
  assign next_addr = addr_sum[ADDR_W-1:0];
  assign idx_last  = ({1'b0, idx} == (len - LEN_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      base                 <= '0;
      len                  <= '0;
      idx                  <= '0;
      mem_rd               <= 1'b0;
      mem_addr             <= '0;
      wr_en                <= 1'b0;
      wr_index             <= '0;
      wr_data              <= '0;
      busy                 <= 1'b0;
      image_weights_loaded <= 1'b0;
      req_err              <= 1'b0;
    end else begin
      wr_en                <= 1'b0;
      image_weights_loaded <= 1'b0;
      // DONE still counts as busy for request rejection
      req_err              <= request_coef && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (request_coef) begin
            base     <= sel_base;
            len      <= sel_len;
            idx      <= '0;
            mem_addr <= sel_base;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_READ;
          end
        end
        S_READ: begin
          if (mem_ready) begin
            mem_rd   <= 1'b0;
            wr_en    <= 1'b1;
            wr_index <= idx;
            wr_data  <= mem_rdata;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (idx_last) begin
            busy                 <= 1'b0;
            image_weights_loaded <= 1'b1;
            state                <= S_DONE;
          end else begin
            idx      <= idx + IDX_W'(1);
            mem_addr <= next_addr;
            mem_rd   <= 1'b1;
            state    <= S_READ;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ann_coef_fetcher.sv
// Bench for ann_coef_fetcher: table of block fetches plus randomized fetches, all
// checked against a word-level model of the block layout and per-word timing.
module tb_ann_coef_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        request_coef;
  logic [1:0]  coef_select;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        wr_en;
  logic [10:0] wr_index;
  logic [15:0] wr_data;
  logic        busy;
  logic        image_weights_loaded;
  logic        req_err;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] salt;

  ann_coef_fetcher #(
    .IMAGE_SIZE(64), .FIRST_LAYER(16), .SECOND_LAYER(8), .THIRD_LAYER(10),
    .BASE_ADDR(0), .ADDR_W(16), .DATA_W(16), .IDX_W(11)
  ) dut (
    .clk(clk), .rst(rst), .request_coef(request_coef), .coef_select(coef_select),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data), .busy(busy),
    .image_weights_loaded(image_weights_loaded), .req_err(req_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    int         dly;       // fixed ready delay per read, -1 = random per word
    bit         toggle;    // scramble coef_select during the fetch
    int         inj;       // cycle of a second request, -1 = none
    int         exp_base;
    int         exp_len;
  } vec_t;

  function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] memf(input int unsigned a);
    int unsigned p;
    p = (a & 32'hFFFF) * 32'h9E37;
    return p[15:0] ^ salt;
  endfunction

  // Block layout model: image, then L0, L1, L2 back to back from address 0
  function automatic void ref_block(input logic [1:0] s, output int b, output int l);
    int sz[4];
    sz[0] = 64; sz[1] = 64 * 16; sz[2] = 16 * 8; sz[3] = 8 * 10;
    case (s)
      2'b11:   begin b = 0;                     l = sz[0]; end
      2'b00:   begin b = sz[0];                 l = sz[1]; end
      2'b01:   begin b = sz[0] + sz[1];         l = sz[2]; end
      default: begin b = sz[0] + sz[1] + sz[2]; l = sz[3]; end
    endcase
  endfunction

  task automatic run_fetch(input vec_t v);
    int c, k, rs, dcur, P, c_ld;
    bit done, exp_rd, exp_wr;
    c = 0; k = 0; rs = 0; dcur = 0; done = 0; c_ld = -1;
    P = v.dly + 2;
    @(negedge clk);
    request_coef = 1'b1;
    coef_select  = v.sel;
    mem_ready    = 1'b0;
    while (!done && c < v.exp_len * 5 + 10) begin
      @(negedge clk);
      c++;
      chk("req_err", req_err, (c == v.inj + 1));
      chk("busy", busy, (k < v.exp_len));
      chk("loaded", image_weights_loaded, (k == v.exp_len));
      if (v.dly >= 0) begin
        exp_rd = (c <= v.exp_len * P) && (((c - 1) % P) <= v.dly);
        exp_wr = (c <= v.exp_len * P) && (((c - 1) % P) == v.dly + 1);
        chk("mem_rd_timing", mem_rd, exp_rd);
        chk("wr_en_timing", wr_en, exp_wr);
        if (image_weights_loaded) chk("loaded_cycle", c, v.exp_len * P + 1);
      end else if (mem_rd && wr_en) begin
        chk("rd_wr_exclusive", wr_en, 0);
      end
      if (mem_rd) chk("mem_addr", mem_addr, (v.exp_base + k) % 65536);
      if (wr_en) begin
        chk("wr_in_range", (k < v.exp_len), 1);
        chk("wr_index", wr_index, k);
        chk("wr_data", wr_data, memf(v.exp_base + k));
        k++;
      end
      if (image_weights_loaded) begin
        done = 1;
        c_ld = c;
      end
      // drive the next cycle's inputs
      request_coef = (c == v.inj);
      if (c == v.inj) coef_select = 2'b01;
      else if (v.toggle) coef_select = 2'($urandom);
      if (mem_rd) begin
        if (rs == 0) dcur = (v.dly < 0) ? int'($urandom_range(0, 3)) : v.dly;
        mem_ready = (rs == dcur);
        mem_rdata = memf(mem_addr);
        rs = mem_ready ? 0 : rs + 1;
      end else begin
        mem_ready = 1'($urandom);
        mem_rdata = 16'($urandom);
        rs = 0;
      end
    end
    chk("loaded_seen", done, 1);
    @(negedge clk);
    chk("post_req_err", req_err, (v.inj >= 0 && v.inj == c_ld));
    chk("post_busy", busy, 0);
    chk("post_loaded", image_weights_loaded, 0);
    request_coef = 1'b0;
    mem_ready    = 1'b0;
    @(negedge clk);
    chk("post_idle_rd", mem_rd, 0);
    chk("post_idle_busy", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_index"}, wr_index, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_loaded"}, image_weights_loaded, 0);
    chk({tag, "_req_err"}, req_err, 0);
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    bit hit;
    salt = 16'($urandom);
    rst = 1'b1; request_coef = 1'b0; coef_select = 2'b00;
    mem_ready = 1'b0; mem_rdata = '0;

    vecs[0] = '{sel: 2'b11, dly:  0, toggle: 0, inj: -1,  exp_base: 0,    exp_len: 64};
    vecs[1] = '{sel: 2'b10, dly:  3, toggle: 0, inj: -1,  exp_base: 1216, exp_len: 80};
    vecs[2] = '{sel: 2'b00, dly:  0, toggle: 0, inj: -1,  exp_base: 64,   exp_len: 1024};
    vecs[3] = '{sel: 2'b11, dly:  0, toggle: 0, inj: 30,  exp_base: 0,    exp_len: 64};
    vecs[4] = '{sel: 2'b01, dly: -1, toggle: 1, inj: -1,  exp_base: 1088, exp_len: 128};
    vecs[5] = '{sel: 2'b10, dly:  1, toggle: 0, inj: 5,   exp_base: 1216, exp_len: 80};
    vecs[6] = '{sel: 2'b11, dly:  0, toggle: 0, inj: 129, exp_base: 0,    exp_len: 64};
    vecs[7] = '{sel: 2'b01, dly:  2, toggle: 1, inj: -1,  exp_base: 1088, exp_len: 128};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_fetch(vecs[i]);

    // Reset while word 20 of an L0 fetch is being read
    @(negedge clk);
    request_coef = 1'b1; coef_select = 2'b00; mem_ready = 1'b1;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      request_coef = 1'b0;
      mem_rdata = memf(mem_addr);
      if (mem_rd && mem_addr == 16'd84) hit = 1;
    end
    chk("reached_word20", hit, 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("after_rst_loaded", image_weights_loaded, 0);
      chk("after_rst_busy", busy, 0);
    end
    mem_ready = 1'b0;
    rv = '{sel: 2'b11, dly: 0, toggle: 0, inj: -1, exp_base: 0, exp_len: 64};
    run_fetch(rv);

    // Randomized fetches against the layout model
    for (int i = 0; i < 6; i++) begin
      rv.sel    = 2'($urandom);
      rv.dly    = int'($urandom_range(0, 4)) - 1;
      rv.toggle = 1'($urandom);
      rv.inj    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 60)) : -1;
      ref_block(rv.sel, rv.exp_base, rv.exp_len);
      run_fetch(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
